// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow complete in one cycle.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        rem_sel_q, rem_sel_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;

    logic        is_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [33:0] shifted, trial;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        rem_sel_d = rem_sel_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        done_d    = 1'b0;

        is_signed = ~op[0];
        a_neg     = is_signed & dividend[31];
        b_neg     = is_signed & divisor[31];
        // Magnitude of 0x80000000 wraps to itself, which is correct read as unsigned.
        a_mag     = a_neg ? -dividend : dividend;
        b_mag     = b_neg ? -divisor  : divisor;

        // Top bit of the partial remainder is always 0 here, so bit 33 of trial is the borrow.
        shifted   = {rem_q, quo_q[31]};
        trial     = shifted - {2'b00, dvs_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == 32'h0) begin
                        result_d = op[1] ? dividend : 32'hFFFF_FFFF;
                        done_d   = 1'b1;
                    end else if (is_signed && dividend == 32'h8000_0000 &&
                                 divisor == 32'hFFFF_FFFF) begin
                        result_d = op[1] ? 32'h0 : 32'h8000_0000;
                        done_d   = 1'b1;
                    end else begin
                        rem_sel_d = op[1];
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        dvs_d     = b_mag;
                        quo_d     = a_mag;
                        rem_d     = 33'h0;
                        cnt_d     = 5'd0;
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = trial[33] ? shifted[32:0] : trial[32:0];
                quo_d = {quo_q[30:0], ~trial[33]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31)
                    state_d = FINISH;
            end
            FINISH: begin
                if (rem_sel_q)
                    result_d = neg_rem_q ? -rem_q[31:0] : rem_q[31:0];
                else
                    result_d = neg_quo_q ? -quo_q : quo_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            rem_q     <= 33'h0;
            quo_q     <= 32'h0;
            dvs_q     <= 32'h0;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            rem_sel_q <= rem_sel_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: per-cycle compare against an arithmetic
// reference model, plus directed literal cases and randomized operands.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = 32'h0;
    logic [31:0] divisor = 32'h0;
    logic        busy, done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result from plain integer arithmetic (truncating division).
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'h0, a});
            y = longint'({32'h0, b});
        end
        q = x / y;
        r = x % y;
        return o[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Cycle-level model: expected busy/done/result after each rising edge.
    bit          m_pend = 1'b0;
    bit          m_was_pend;
    bit          m_done = 1'b0;
    int          m_left = 0;
    logic [31:0] m_hold = 32'h0;
    logic [31:0] m_res = 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 1'b0;
            m_left = 0;
            m_done = 1'b0;
            m_res  = 32'h0;
        end else begin
            m_was_pend = m_pend;
            m_done     = 1'b0;
            if (m_pend) begin
                m_left--;
                if (m_left == 0) begin
                    m_pend = 1'b0;
                    m_done = 1'b1;
                    m_res  = m_hold;
                end
            end
            if (!m_was_pend && start) begin
                if (is_special(op, dividend, divisor)) begin
                    m_done = 1'b1;
                    m_res  = ref_div(op, dividend, divisor);
                end else begin
                    m_pend = 1'b1;
                    m_left = 33;
                    m_hold = ref_div(op, dividend, divisor);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("mon busy", busy, m_pend);
            chk("mon done", done, m_done);
            chk("mon result", result, m_res);
        end
    end

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op       = o;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        op       = 2'($urandom);
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Called on the negedge after the accepting edge; returns on the done cycle.
    task automatic wait_done(input string name, input logic [31:0] exp, input int exp_edges, input int poke_at);
        int edges = 0;
        int busy_cnt = 0;
        bit poked;
        while (!done && edges < 40) begin
            if (busy) busy_cnt++;
            poked = (edges == poke_at);
            if (poked) begin
                start    = 1'b1;
                op       = 2'b01;
                dividend = 32'd1000;
                divisor  = 32'd3;
            end
            @(negedge clk);
            edges++;
            if (poked) start = 1'b0;
        end
        chk({name, " done seen"}, done, 1'b1);
        chk({name, " result"}, result, exp);
        chk({name, " latency"}, edges, exp_edges);
        chk({name, " busy cycles"}, busy_cnt, (exp_edges == 0) ? 0 : 33);
    endtask

    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    int          mode;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset result", result, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        chk("model div -7/2", ref_div(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        chk("model rem -7/2", ref_div(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("model div ovf", ref_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

        launch(2'b01, 32'd100, 32'd7);                 wait_done("divu 100/7", 32'h0000_000E, 33, -1);
        launch(2'b11, 32'd100, 32'd7);                 wait_done("remu 100/7", 32'h0000_0002, 33, -1);
        launch(2'b00, 32'hFFFF_FFF9, 32'd2);           wait_done("div -7/2", 32'hFFFF_FFFD, 33, -1);
        launch(2'b10, 32'hFFFF_FFF9, 32'd2);           wait_done("rem -7/2", 32'hFFFF_FFFF, 33, -1);
        launch(2'b00, 32'd7, 32'hFFFF_FFFE);           wait_done("div 7/-2", 32'hFFFF_FFFD, 33, -1);
        launch(2'b01, 32'd5, 32'd0);                   wait_done("divu 5/0", 32'hFFFF_FFFF, 0, -1);
        launch(2'b10, 32'hFFFF_FFFB, 32'd0);           wait_done("rem -5/0", 32'hFFFF_FFFB, 0, -1);
        launch(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done("div ovf", 32'h8000_0000, 0, -1);
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done("rem ovf", 32'h0, 0, -1);
        launch(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done("divu ovf operands", 32'h0, 33, -1);
        launch(2'b01, 32'hFFFF_FFFF, 32'd1);           wait_done("divu max/1 poked", 32'hFFFF_FFFF, 33, 5);
        // Launched on the done cycle: must be accepted straight away.
        launch(2'b01, 32'd100, 32'd7);                 wait_done("back-to-back", 32'h0000_000E, 33, -1);

        launch(2'b01, 32'hDEAD_BEEF, 32'h0000_0123);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort busy", busy, 1'b0);
        chk("abort result", result, 32'h0);
        chk("abort done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        launch(2'b00, 32'hFFFF_FF9C, 32'd7);           wait_done("after abort", 32'hFFFF_FFF2, 33, -1);

        repeat (40) begin
            mode = $urandom_range(0, 5);
            r_op = 2'($urandom);
            r_a  = $urandom;
            r_b  = $urandom;
            case (mode)
                0: r_b = 32'h0;
                1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                2: begin r_a = $urandom_range(0, 1000); r_b = $urandom_range(1, 20); end
                3: r_b = $urandom_range(1, 255) | (r_b & 32'h8000_0000);
                default: ;
            endcase
            launch(r_op, r_a, r_b);
            wait_done("random", ref_div(r_op, r_a, r_b), is_special(r_op, r_a, r_b) ? 0 : 33, -1);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
